// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

   localparam int FQ_PC_W  = 9;
   localparam int FQ_INS_W = 32;
   localparam int PC_STEP  = 4;

   // Queue entry layout; the FIFO stores it flattened as {pc, instr}.
   typedef struct packed {
      logic [FQ_PC_W-1:0]  pc;
      logic [FQ_INS_W-1:0] instr;
   } fq_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular prefetch buffer with flush; head entry is held in a register
// so the output stays stable and resets to zero.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = FQ_PC_W + FQ_INS_W,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          flush,
   input  logic          wr_en,
   input  logic [W-1:0]  wr_data,
   input  logic          rd_en,
   output logic [W-1:0]  rd_data,
   output logic [CW-1:0] count
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [CW-1:0] count_reg;
   logic [W-1:0]  data_reg;

   logic [AW-1:0] rd_ptr_next;
   logic [CW-1:0] after_deq;
   logic [CW-1:0] count_next;

   always_comb begin
      rd_ptr_next = rd_ptr_reg + AW'(rd_en);
      after_deq   = count_reg - CW'(rd_en);
      count_next  = after_deq + CW'(wr_en);
   end

   always_ff @(posedge clk) begin
      if (reset && !flush && wr_en)
         mem[wr_ptr_reg] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         data_reg   <= '0;
      end else if (flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (wr_en)
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         rd_ptr_reg <= rd_ptr_next;
         count_reg  <= count_next;
         // Forward the incoming word when it becomes the new head of an empty queue.
         if (after_deq == '0 && wr_en)
            data_reg <= wr_data;
         else if (after_deq != '0)
            data_reg <= mem[rd_ptr_next];
      end
   end

   always_ff @(posedge clk) begin
      if (reset && !flush && wr_en)
         assert (count_reg < CW'(DEPTH));
   end

   assign rd_data = data_reg;
   assign count   = count_reg;

endmodule

// File: rtl/fetch_queue.sv
// Decoupled fetch front end: owns the fetch PC, issues imem reads only when
// queue space is reserved, and kills in-flight data on redirect.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int              PC_W     = FQ_PC_W,
   parameter int              INS_W    = FQ_INS_W,
   parameter int              DEPTH    = 4,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   localparam int             CW       = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   output logic             imem_req,
   output logic [PC_W-1:0]  imem_addr,
   input  logic [INS_W-1:0] imem_rdata,
   input  logic             redirect,
   input  logic [PC_W-1:0]  redirect_pc,
   input  logic             deq_ready,
   output logic             out_valid,
   output logic [PC_W-1:0]  out_pc,
   output logic [INS_W-1:0] out_instr,
   output logic [CW-1:0]    count
);

   logic [PC_W-1:0]       fetch_pc_reg;
   logic [PC_W-1:0]       req_pc_reg;
   logic                  inflight_reg;
   logic [CW:0]           pending;
   logic                  deq;
   logic [PC_W+INS_W-1:0] head;

   // Counting the in-flight word as occupied is what makes overflow impossible.
   always_comb begin
      pending   = {1'b0, count} + (CW+1)'(inflight_reg);
      imem_req  = reset & ~redirect & (pending < (CW+1)'(DEPTH));
      imem_addr = fetch_pc_reg;
      out_valid = (count != '0);
      deq       = out_valid & deq_ready & ~redirect;
      out_pc    = head[INS_W +: PC_W];
      out_instr = head[INS_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         fetch_pc_reg <= RESET_PC;
         req_pc_reg   <= '0;
         inflight_reg <= 1'b0;
      end else begin
         inflight_reg <= imem_req;
         req_pc_reg   <= fetch_pc_reg;
         if (redirect)
            fetch_pc_reg <= redirect_pc;
         else if (imem_req)
            fetch_pc_reg <= fetch_pc_reg + PC_W'(PC_STEP);
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH),
      .W     (PC_W + INS_W)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .flush   (redirect),
      .wr_en   (inflight_reg),
      .wr_data ({req_pc_reg, imem_rdata}),
      .rd_en   (deq),
      .rd_data (head),
      .count   (count)
   );

endmodule
